// File: rtl/e_mdu.sv
// e_mdu: execute-stage MIPS multiply/divide unit holding the HI/LO registers
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_enable,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rdata1,
  input  logic [31:0] in_rdata2,
  output logic        out_start,
  output logic        out_busy,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic special, is_md, is_mthi, is_mtlo, done, sgn, neg_a, neg_b, div_zero, unused_ok;
  logic [63:0] prod, res;
  logic [31:0] ua, ub, uq, ur;
  assign special = in_instr[31:26] == 6'b0;
  assign is_md = special && in_instr[5:2] == 4'b0110;
  assign is_mthi = special && in_instr[5:0] == 6'h11;
  assign is_mtlo = special && in_instr[5:0] == 6'h13;
  assign out_busy = state_q == BUSY;
  assign out_start = in_enable && is_md && !out_busy;
  assign done = out_busy && cnt_q == CW'(1);
  assign out_hi = hi_q;
  assign out_lo = lo_q;
  assign unused_ok = ^in_instr[25:6];
  always_comb begin
    sgn = !op_q[0];
    neg_a = sgn && a_q[31];
    neg_b = sgn && b_q[31];
    prod = {{32{neg_a}}, a_q} * {{32{neg_b}}, b_q};
    ua = neg_a ? -a_q : a_q;
    ub = neg_b ? -b_q : b_q;
    uq = ua / ub;
    ur = ua % ub;
    res = op_q[1] ? {neg_a ? -ur : ur, (neg_a ^ neg_b) ? -uq : uq} : prod;
    div_zero = op_q[1] && b_q == 32'b0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (out_start) begin
      state_d = BUSY;
      cnt_d = in_instr[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      op_d = in_instr[1:0];
      a_d = in_rdata1;
      b_d = in_rdata2;
    end else if (out_busy) begin
      cnt_d = cnt_q - CW'(1);
      state_d = done ? IDLE : BUSY;
      hi_d = done && !div_zero ? res[63:32] : hi_q;
      lo_d = done && !div_zero ? res[31:0] : lo_q;
    end else if (in_enable) begin
      hi_d = is_mthi ? in_rdata1 : hi_q;
      lo_d = is_mtlo ? in_rdata1 : lo_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed stimulus with a cycle model of HI/LO/busy and literal pins
module tb_e_mdu;
  logic clk = 0, reset, in_enable, out_start, out_busy;
  logic [31:0] in_instr, in_rdata1, in_rdata2, out_hi, out_lo;
  int n_checks = 0, n_errors = 0;
  e_mdu dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .in_instr(in_instr),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .out_start(out_start),
    .out_busy(out_busy), .out_hi(out_hi), .out_lo(out_lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic is_md(input logic en, input logic [31:0] ins);
    return en && ins[31:26] == 6'b0 && ins[5:0] >= 6'h18 && ins[5:0] <= 6'h1b;
  endfunction
  logic m_valid = 0, pend = 0, skip;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  longint edges = 0, done_at = 0;
  always @(posedge clk) begin
    logic st, sp;
    logic [5:0] f;
    longint sa, sb, pr;
    edges++;
    f = in_instr[5:0];
    sp = in_enable && in_instr[31:26] == 6'b0 && !pend;
    st = is_md(in_enable, in_instr) && !pend;
    if (reset) begin
      m_hi = 0;
      m_lo = 0;
      pend = 0;
      m_valid = 1;
    end else begin
      if (pend && edges == done_at) begin
        if (!skip) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
        pend = 0;
      end
      if (st) begin
        pend = 1;
        done_at = edges + (f[1] ? 10 : 5);
        skip = f[1] && in_rdata2 == 0;
        sa = f[0] ? longint'({32'b0, in_rdata1}) : longint'($signed(in_rdata1));
        sb = f[0] ? longint'({32'b0, in_rdata2}) : longint'($signed(in_rdata2));
        if (!f[1]) begin
          pr = sa * sb;
          p_hi = pr[63:32];
          p_lo = pr[31:0];
        end else if (!skip) begin
          pr = sa % sb;
          p_hi = pr[31:0];
          pr = sa / sb;
          p_lo = pr[31:0];
        end
      end else if (sp && f == 6'h11) m_hi = in_rdata1;
      else if (sp && f == 6'h13) m_lo = in_rdata1;
    end
  end
  always @(negedge clk) if (m_valid) begin
    check("cyc_busy", {31'b0, out_busy}, {31'b0, pend});
    check("cyc_start", {31'b0, out_start}, {31'b0, is_md(in_enable, in_instr) && !pend});
    check("cyc_hi", out_hi, m_hi);
    check("cyc_lo", out_lo, m_lo);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic en, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    in_enable = en;
    in_instr = {6'b0, 5'd3, 5'd4, 10'h0, f};
    in_rdata1 = a;
    in_rdata2 = b;
  endtask
  task automatic idle();
    drive(0, 6'h0, 32'h0, 32'h0);
  endtask
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    drive(1, f, a, b);
    #1 check("issue_start", {31'b0, out_start}, 32'd1);
    cyc();
    idle();
  endtask
  task automatic busy_len(input string name, input int exp);
    int n = 0;
    while (out_busy && n < 40) begin
      n++;
      cyc();
    end
    check(name, n, exp);
  endtask
  initial begin
    #200000 $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    reset = 1;
    in_enable = 1;
    in_instr = 32'hFFFFFFFF;
    in_rdata1 = 32'hDEADBEEF;
    in_rdata2 = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", out_hi, 0);
    check("rst_lo", out_lo, 0);
    check("rst_busy", {31'b0, out_busy}, 0);
    check("rst_start", {31'b0, out_start}, 0);
    reset = 0;
    idle();
    cyc();
    issue(6'h18, 32'hFFFFFFFF, 32'd2);
    busy_len("mult_busy", 5);
    check("mult_hi", out_hi, 32'hFFFFFFFF);
    check("mult_lo", out_lo, 32'hFFFFFFFE);
    issue(6'h19, 32'hFFFFFFFF, 32'd2);
    busy_len("multu_busy", 5);
    check("multu_hi", out_hi, 32'h00000001);
    check("multu_lo", out_lo, 32'hFFFFFFFE);
    issue(6'h1a, 32'hFFFFFFF9, 32'd2);
    busy_len("div_busy", 10);
    check("div_hi", out_hi, 32'hFFFFFFFF);
    check("div_lo", out_lo, 32'hFFFFFFFD);
    issue(6'h1b, 32'hFFFFFFF9, 32'd2);
    busy_len("divu_busy", 10);
    check("divu_hi", out_hi, 32'h00000001);
    check("divu_lo", out_lo, 32'h7FFFFFFC);
    issue(6'h1a, 32'h80000000, 32'hFFFFFFFF);
    busy_len("divovf_busy", 10);
    check("divovf_hi", out_hi, 32'h0);
    check("divovf_lo", out_lo, 32'h80000000);
    drive(1, 6'h11, 32'h12345678, 32'h0);
    cyc();
    check("mthi_hi", out_hi, 32'h12345678);
    check("mthi_busy", {31'b0, out_busy}, 0);
    drive(1, 6'h13, 32'h9ABCDEF0, 32'h0);
    cyc();
    idle();
    check("mtlo_lo", out_lo, 32'h9ABCDEF0);
    issue(6'h1a, 32'd55, 32'd0);
    busy_len("div0_busy", 10);
    check("div0_hi", out_hi, 32'h12345678);
    check("div0_lo", out_lo, 32'h9ABCDEF0);
    issue(6'h18, 32'd3, 32'd4);
    drive(1, 6'h18, 32'd5, 32'd6);
    #1 check("ign_mult_start", {31'b0, out_start}, 0);
    cyc();
    drive(1, 6'h13, 32'h55, 32'h0);
    cyc();
    idle();
    busy_len("ign_busy", 3);
    check("ign_hi", out_hi, 0);
    check("ign_lo", out_lo, 32'd12);
    drive(0, 6'h18, 32'd9, 32'd9);
    #1 check("dis_start", {31'b0, out_start}, 0);
    cyc();
    idle();
    check("dis_busy", {31'b0, out_busy}, 0);
    check("dis_lo", out_lo, 32'd12);
    issue(6'h1a, 32'd100, 32'd7);
    cyc();
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    check("midrst_busy", {31'b0, out_busy}, 0);
    check("midrst_lo", out_lo, 0);
    repeat (15) cyc();
    check("late_hi", out_hi, 0);
    check("late_lo", out_lo, 0);
    issue(6'h18, 32'd7, 32'd6);
    busy_len("b2b1_busy", 5);
    check("b2b1_lo", out_lo, 32'd42);
    issue(6'h18, 32'hFFFFFFFD, 32'd5);
    check("b2b_mid_lo", out_lo, 32'd42);
    busy_len("b2b2_busy", 5);
    check("b2b2_hi", out_hi, 32'hFFFFFFFF);
    check("b2b2_lo", out_lo, 32'hFFFFFFF1);
    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, and MTHI/MTLO writes in a single cycle.
- Holds the architectural HI/LO registers and drives them to the E/M pipeline register's hi/lo inputs.
- Exports start/busy to the D-stage hazard unit so it can stall MD-class instructions.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_enable  input  1  E-stage instruction valid; low means bubble or flushed, and the instruction has no effect.
- in_instr  input  32  E-stage instruction word.
- in_rdata1  input  32  forwarded rs value.
- in_rdata2  input  32  forwarded rt value.
- out_start  output  1  combinational: E-stage instruction is an accepted MULT/MULTU/DIV/DIVU this cycle.
- out_busy  output  1  registered: an operation is in progress.
- out_hi  output  32  registered HI.
- out_lo  output  32  registered LO.

Behaviour:
- Decode uses opcode 6'b000000 with funct: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13. MFHI and MFLO need no action here; they read out_hi/out_lo through the pipeline.
- Reset: out_hi=0, out_lo=0, out_busy=0, counter=0, operand/op latches=0. Reset mid-operation discards the pending result; HI/LO stay 0.
- States: IDLE (busy=0) and BUSY (busy=1). A down-counter holds the remaining busy cycles.
- out_start = in_enable & is_md_op & ~out_busy.
- Accept edge (out_start=1 at posedge t0):
  - latch rs, rt and op;
  - counter <= MULT_CYCLES or DIV_CYCLES;
  - busy <= 1.
- BUSY: each posedge decrements the counter. On the edge where counter==1:
  - write HI/LO with the result;
  - busy <= 0;
  - go to IDLE.
- Timing: busy is high for exactly N cycles (t0+1 .. t0+N). New HI/LO are visible in cycle t0+N+1, the same cycle busy is first low. A back-to-back start is allowed in that cycle.
- Results:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (latched rt==0): HI and LO are left unchanged at completion. Busy timing is the same as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO with in_enable=1 and busy=0: at that edge HI (or LO) <= in_rdata1; no busy cycles.
- MD op, MTHI or MTLO with busy=1: ignored, with no effect on state or out_start. The hazard unit stalls these in D, so this condition is a protocol violation; ignoring it is defined behaviour only.
- in_enable=0: no state change other than busy countdown.
- HI/LO change only at reset, at MT* edges and at the completion edge.

Test Plan:
1. Reset held for 2 cycles with garbage on the inputs -> out_hi=out_lo=0, out_busy=0, out_start=0.
2. MULT with rs=0xFFFFFFFF, rt=2 -> out_start=1 in the issue cycle; busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat as MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
3. DIV with rs=0xFFFFFFF9 (-7), rt=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
4. MTHI with rs=0x12345678, then MTLO with rs=0x9ABCDEF0 on consecutive cycles -> HI/LO update on each edge with no busy. Then DIV with rt=0 -> busy for 10 cycles; HI/LO stay 0x12345678/0x9ABCDEF0.
5. MULT issued while another MULT is busy, or MTLO while busy, or any MD op with in_enable=0 -> ignored; out_start=0; the first result is unaffected.
6. Reset asserted at busy cycle 3 of a DIV -> next cycle busy=0 and HI=LO=0; no late write-back afterwards. Back-to-back: a second MULT issued in the first non-busy cycle -> accepted and uses the freshly written HI/LO timing.
